// File: rtl/gray_code_pipe.sv
// gray_code_pipe: pipelined Gray<->binary converter with valid/ready handshake, optional parity via GRAY_CODE_PIPE_PARITY_EN
module gray_code_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
`ifdef GRAY_CODE_PIPE_PARITY_EN
  input  logic                  parity_i,
  output logic                  err_o,
`endif
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  mode_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int C = (DATA_WIDTH + STAGES - 1) / STAGES;
  if (DATA_WIDTH < 1 || DATA_WIDTH > 64 || STAGES < 1 || STAGES > DATA_WIDTH) begin : g_bad
    $error("gray_code_pipe: illegal DATA_WIDTH/STAGES");
  end
  logic [STAGES-1:0] vld, md, ld;
  logic [STAGES:0] vi, mi;
  logic [DATA_WIDTH-1:0] dat [STAGES];
  logic [DATA_WIDTH-1:0] din [STAGES];
  function automatic logic [DATA_WIDTH-1:0] step(input int k, input logic m, input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = (m && k == 0) ? d ^ (d >> 1) : d;
    for (int i = DATA_WIDTH - 2; i >= 0; i--)
      if (!m && i <= DATA_WIDTH - 1 - k * C && i >= DATA_WIDTH - (k + 1) * C) r[i] = r[i + 1] ^ r[i];
    return r;
  endfunction
  assign vi = {vld, valid_i};
  assign mi = {md, mode_i};
  always_comb begin
    logic nx;
    nx = ready_i;
    ld = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !vld[k] | nx;
      nx = ld[k];
    end
  end
  always_comb
    for (int k = 0; k < STAGES; k++)
      din[k] = step(k, mi[k], k == 0 ? data_i : dat[k == 0 ? 0 : k - 1]);
`ifdef GRAY_CODE_PIPE_PARITY_EN
  logic [STAGES-1:0] er;
  logic [STAGES:0] ei;
  assign ei = {er, ^data_i ^ parity_i};
  assign err_o = er[STAGES-1];
`endif
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      vld <= '0;
      md <= '0;
      for (int k = 0; k < STAGES; k++) dat[k] <= '0;
`ifdef GRAY_CODE_PIPE_PARITY_EN
      er <= '0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (ld[k]) begin
          vld[k] <= vi[k];
          md[k] <= mi[k];
          dat[k] <= din[k];
`ifdef GRAY_CODE_PIPE_PARITY_EN
          er[k] <= ei[k];
`endif
        end
    end
  assign ready_o = ld[0];
  assign valid_o = vld[STAGES-1];
  assign mode_o = md[STAGES-1];
  assign data_o = dat[STAGES-1];
endmodule

// File: tb/tb_gray_code_pipe.sv
// tb_gray_code_pipe: scoreboard bench for gray_code_pipe
module tb_gray_code_pipe;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 0, rst_n = 0, valid_i = 0, mode_i = 0, ready_i = 1;
  logic ready_o, valid_o, mode_o;
  logic [W-1:0] data_i = '0, data_o, exp_d = '0;
  logic v1 = 0, m1 = 0, r1o, vo1, mo1;
  logic [0:0] d1 = '0, d1o;
  logic v13 = 0, m13 = 0, r13o, vo13, mo13;
  logic [12:0] d13 = '0, d13o;
  int errors = 0, checks = 0;
  bit done = 0;
  typedef struct packed {logic m; logic e; logic [W-1:0] d;} beat_t;
  beat_t q[$];
`ifdef GRAY_CODE_PIPE_PARITY_EN
  logic parity_i = 0, err_o, p1 = 0, e1o, p13 = 0, e13o;
`endif
  always #5 clk = ~clk;
  gray_code_pipe #(.DATA_WIDTH(W), .STAGES(S)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o), .mode_i(mode_i), .data_i(data_i),
`ifdef GRAY_CODE_PIPE_PARITY_EN
    .parity_i(parity_i), .err_o(err_o),
`endif
    .valid_o(valid_o), .ready_i(ready_i), .mode_o(mode_o), .data_o(data_o));
  gray_code_pipe #(.DATA_WIDTH(1), .STAGES(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(v1), .ready_o(r1o), .mode_i(m1), .data_i(d1),
`ifdef GRAY_CODE_PIPE_PARITY_EN
    .parity_i(p1), .err_o(e1o),
`endif
    .valid_o(vo1), .ready_i(1'b1), .mode_o(mo1), .data_o(d1o));
  gray_code_pipe #(.DATA_WIDTH(13), .STAGES(4)) dut13 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(v13), .ready_o(r13o), .mode_i(m13), .data_i(d13),
`ifdef GRAY_CODE_PIPE_PARITY_EN
    .parity_i(p13), .err_o(e13o),
`endif
    .valid_o(vo13), .ready_i(1'b1), .mode_o(mo13), .data_o(d13o));
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] e);
    bit acc;
    int n;
    valid_i = 1;
    mode_i = m;
    data_i = d;
    exp_d = e;
    n = 0;
    do begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    if (!acc) chk("send timeout ready_o", ready_o, 1);
    valid_i = 0;
  endtask
  always @(negedge clk)
    if (!rst_n) q.delete();
    else if (valid_i && ready_o) begin
      beat_t b;
      b.m = mode_i;
      b.d = exp_d;
`ifdef GRAY_CODE_PIPE_PARITY_EN
      b.e = ^data_i ^ parity_i;
`else
      b.e = 1'b0;
`endif
      q.push_back(b);
    end
  always @(negedge clk) begin
    beat_t b;
    logic held;
    logic [W:0] last;
    if (rst_n && valid_o && !ready_i) begin
      if (held) chk("stall hold", {mode_o, data_o}, last);
      held = 1;
      last = {mode_o, data_o};
    end else held = 0;
    if (rst_n && valid_o && ready_i) begin
      if (q.size() == 0) chk("spurious beat valid_o", valid_o, 0);
      else begin
        b = q.pop_front();
        chk("out data", data_o, b.d);
        chk("out mode", mode_o, b.m);
`ifdef GRAY_CODE_PIPE_PARITY_EN
        chk("out err", err_o, b.e);
`endif
      end
    end
  end
  initial begin
    int lat1, lat13, n;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", valid_o, 0);
    chk("reset ready_o", ready_o, 1);
    chk("reset data_o", data_o, 0);
    chk("reset mode_o", mode_o, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    send(0, 8'hC5, 8'h86);
    @(negedge clk);
    chk("latency early valid_o", valid_o, 0);
    @(negedge clk);
    chk("latency valid_o", valid_o, 1);
    chk("c5 data_o", data_o, 8'h86);
    @(posedge clk);
    #1;
    send(1, 8'hFF, 8'h80);
    send(0, 8'h80, 8'hFF);
    @(negedge clk);
    chk("b2b first valid", valid_o, 1);
    chk("b2b first data", {mode_o, data_o}, {1'b1, 8'h80});
    @(negedge clk);
    chk("b2b second valid", valid_o, 1);
    chk("b2b second data", {mode_o, data_o}, {1'b0, 8'hFF});
    @(posedge clk);
    #1;
    ready_i = 0;
    send(1, 8'h01, 8'h01);
    send(1, 8'h02, 8'h03);
    valid_i = 1;
    mode_i = 1;
    data_i = 8'h03;
    exp_d = 8'h02;
    repeat (2) begin
      @(negedge clk);
      chk("full ready_o", ready_o, 0);
      chk("full valid_o", valid_o, 1);
    end
    @(posedge clk);
    #1;
    ready_i = 1;
    for (int i = 3; i < 10; i++) begin
      data_i = W'(i);
      exp_d = W'(i ^ (i >> 1));
      @(negedge clk);
      chk("no bubble ready_o", ready_o, 1);
      chk("no bubble valid_o", valid_o, 1);
      @(posedge clk);
      #1;
    end
    valid_i = 0;
    repeat (3) @(posedge clk);
    #1;
    ready_i = 0;
    send(1, 8'hC5, 8'hA7);
    send(1, 8'h0F, 8'h08);
    rst_n = 0;
    valid_i = 1;
    mode_i = 1;
    data_i = 8'h55;
    @(posedge clk);
    #1;
    chk("rst valid_o", valid_o, 0);
    chk("rst ready_o", ready_o, 1);
    chk("rst data_o", data_o, 0);
    chk("rst mode_o", mode_o, 0);
    rst_n = 1;
    valid_i = 0;
    ready_i = 1;
    repeat (4) begin
      @(negedge clk);
      chk("post rst valid_o", valid_o, 0);
    end
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 256; i++) send(1, W'(i), W'(i ^ (i >> 1)));
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        ready_i = 1'($urandom_range(0, 1));
      end
    join
    ready_i = 1;
`ifdef GRAY_CODE_PIPE_PARITY_EN
    parity_i = 0;
    send(0, 8'h01, 8'h01);
    parity_i = 1;
    send(0, 8'h01, 8'h01);
    @(negedge clk);
    chk("parity err_o set", {err_o, data_o}, {1'b1, 8'h01});
    @(negedge clk);
    chk("parity err_o clear", {err_o, data_o}, {1'b0, 8'h01});
`endif
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain queue empty", q.size(), 0);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      v1 = 1;
      m1 = 1'(m);
      d1 = 1'b1;
      v13 = 1;
      m13 = 1'(m);
      d13 = 13'h1C5;
      @(posedge clk);
      #1;
      v1 = 0;
      v13 = 0;
      lat1 = 0;
      lat13 = 0;
      for (int k = 1; k <= 8; k++) begin
        if (vo1 && lat1 == 0) begin
          lat1 = k;
          chk("w1 data", {mo1, d1o}, {1'(m), 1'b1});
        end
        if (vo13 && lat13 == 0) begin
          lat13 = k;
          chk("w13 data", {mo13, d13o}, {1'(m), m ? 13'h127 : 13'h179});
        end
        @(posedge clk);
        #1;
      end
      chk("w1 latency", lat1, 1);
      chk("w13 latency", lat13, 4);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_code_pipe.md
# gray_code_pipe

Pipelined, parametrised Gray/binary code converter with a valid/ready handshake on both sides. It converts in either direction, chosen per beat. The Gray-to-binary prefix-XOR chain is split across `STAGES` register stages so wide pointers meet timing. It sits between CDC pointer synchronisers and the FIFO/counter logic that consumes binary values, and it accepts back-pressure without dropping or duplicating beats.

## Interface
- `DATA_WIDTH`, 8: code width in bits; legal range 1..64.
- `STAGES`, 2: number of pipeline register stages; legal range 1..`DATA_WIDTH`. Elaboration fails outside this range.
- `clk_i` input 1: clock; all state changes on the rising edge.
- `rst_n_i` input 1: reset, synchronous and active-low.
- `valid_i` input 1: input beat valid.
- `ready_o` output 1: block can accept an input beat.
- `mode_i` input 1: conversion direction for this beat; 0 = Gray→binary, 1 = binary→Gray.
- `data_i` input `DATA_WIDTH`: input code word.
- `valid_o` output 1: output beat valid.
- `ready_i` input 1: downstream accepts the output beat.
- `mode_o` output 1: `mode_i` of the beat currently on the output.
- `data_o` output `DATA_WIDTH`: converted word.
- `parity_i` input 1: even parity of `data_i`. Present only with `GRAY_CODE_PIPE_PARITY_EN`.
- `err_o` output 1: parity error flag for the output beat. Present only with `GRAY_CODE_PIPE_PARITY_EN`.

## Operation
- Chunk size is C = ceil(`DATA_WIDTH`/`STAGES`).
- Stage k (k = 0..`STAGES`-1) resolves binary bits [`DATA_WIDTH`-1-k·C : max(`DATA_WIDTH`-(k+1)·C, 0)], working from MSB to LSB.
- A stage whose bit range is empty (possible when C·`STAGES` > `DATA_WIDTH`) passes its data through unchanged.
- Gray→binary:
  - bin[`DATA_WIDTH`-1] = g[`DATA_WIDTH`-1].
  - bin[i] = bin[i+1] ^ g[i].
  - The MSB-side carry into each stage's chunk is the lowest bit already resolved by the previous stage. It is carried in that stage's data register; no extra state is needed.
- Binary→Gray: stage 0 computes the full result, gray = b ^ (b >> 1). Later stages pass the data through untouched.
- Each stage holds `vld`, `mode`, `data` and, when enabled, the error flag. Mode travels with its beat, so mixed-mode streams are legal back to back.
- Stall rule:
  - Stage k loads when it is empty or when stage k+1 accepts its beat that cycle.
  - The last stage advances on `valid_o & ready_i`.
- `ready_o` = !stage0.vld | stage0 advances this cycle. This is a combinational path from `ready_i` through the chain; no skid buffer.
- The block never drops or reorders beats. Holding `valid_i` without `ready_o` is legal.
- Width/edge cases:
  - `DATA_WIDTH`=1: output equals input in both modes.
  - `STAGES`=1: single register, full conversion in one cycle.

## Timing
- Reset (`rst_n_i`=0 at a clock edge): all stage valids are cleared. `valid_o`=0, `ready_o`=1 after the edge. `data_o`=0, `mode_o`=0, `err_o`=0.
- Reset wins over any simultaneous handshake. In-flight beats are discarded, and a beat presented during reset is not accepted.
- Latency: a beat accepted at edge N appears on `valid_o` after edge N+`STAGES-1`, i.e. `STAGES` register stages.
- Throughput: one beat per cycle while `ready_i`=1.
- While `valid_o`=1 and `ready_i`=0, `data_o`, `mode_o` and `err_o` hold stable.
- Simultaneous accept and emit in a full pipe: allowed in the same cycle, with no bubble.
- `ready_i` low for S cycles with `valid_i` held high: the pipe fills to `STAGES` beats, then `ready_o`=0.

## Configuration
- `GRAY_CODE_PIPE_PARITY_EN` defined:
  - `parity_i`/`err_o` ports exist.
  - Stage 0 computes err = (^`data_i`) ^ `parity_i` and carries it with the beat.
  - `err_o` is valid whenever `valid_o`=1. The data is still converted and delivered.
- `GRAY_CODE_PIPE_PARITY_EN` undefined: the ports are absent, no parity logic exists, and behaviour is otherwise identical.

## Test plan
- W=8, S=2, mode 0, `data_i`=8'hC5, `ready_i`=1 → `data_o`=8'h86, `mode_o`=0, `valid_o` exactly 2 cycles after acceptance.
- Mode 1, `data_i`=8'hFF, then mode 0 with 8'h80 on the next cycle → 8'h80 then 8'hFF on consecutive cycles; `mode_o` tracks each beat.
- Stream 0..255 in mode 1 with `ready_i` random at 50% → outputs equal i^(i>>1) in order; no loss or duplication; data stable while stalled.
- Fill the pipe with `ready_i`=0 → `ready_o`=0 after 2 beats. Release `ready_i` with `valid_i` still high → one beat per cycle with no bubble.
- Assert `rst_n_i`=0 for one cycle with 2 beats in flight → `valid_o`=0, `data_o`=0, `ready_o`=1 after the edge; old beats never emerge.
- Parity build: `data_i`=8'h01, `parity_i`=0 → `err_o`=1 with `data_o`=8'h01 (mode 0). With `parity_i`=1 → `err_o`=0. Also repeat the first scenario at W=1/S=1 and W=13/S=4.
